// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 key decoder: strips E0/F0 prefixes, tracks shift/caps and
// typematic repeats, maps keys to ASCII and queues key events in a valid/ready FIFO.
module ps2_key_decoder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    scan_code,
  input  logic          scan_valid,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [7:0]    ev_code,
  output logic          ev_ext,
  output logic          ev_break,
  output logic          ev_repeat,
  output logic [7:0]    ev_ascii,
  output logic          shift,
  output logic          caps,
  output logic [7:0]    press_count,
  output logic [AW:0]   fifo_level,
  output logic          overflow
);

  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
  } event_t;

  state_e        state_q;
  event_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q;
  logic          shl_q, shr_q, caps_q, ovf_q;
  logic [7:0]    press_q;
  logic [8:0]    last_q;

  logic          is_e0_c, is_f0_c, emit_c, cur_ext_c, cur_brk_c, rep_c, upper_c;
  logic          is_letter_c, full_c, pop_c, push_ok_c, drop_c;
  logic [8:0]    key_c;
  logic [7:0]    raw_c, ascii_c;
  event_t        ev_c;

  // Classify the incoming byte against the pending prefix state
  always_comb begin
    is_e0_c   = (scan_code == 8'hE0);
    is_f0_c   = (scan_code == 8'hF0);
    cur_ext_c = (state_q == EXT) || (state_q == EXTBRK);
    cur_brk_c = (state_q == BRK) || (state_q == EXTBRK);
    emit_c    = scan_valid && !is_e0_c && !is_f0_c;
    key_c     = {cur_ext_c, scan_code};
    rep_c     = !cur_brk_c && (key_c == last_q);
    upper_c   = (shl_q | shr_q) ^ caps_q;
  end

  // Set-2 to ASCII lookup, using shift/caps as they stood before this byte
  always_comb begin
    raw_c = 8'h00;
    case (scan_code)
      8'h1C: raw_c = "a";  8'h32: raw_c = "b";  8'h21: raw_c = "c";  8'h23: raw_c = "d";
      8'h24: raw_c = "e";  8'h2B: raw_c = "f";  8'h34: raw_c = "g";  8'h33: raw_c = "h";
      8'h43: raw_c = "i";  8'h3B: raw_c = "j";  8'h42: raw_c = "k";  8'h4B: raw_c = "l";
      8'h3A: raw_c = "m";  8'h31: raw_c = "n";  8'h44: raw_c = "o";  8'h4D: raw_c = "p";
      8'h15: raw_c = "q";  8'h2D: raw_c = "r";  8'h1B: raw_c = "s";  8'h2C: raw_c = "t";
      8'h3C: raw_c = "u";  8'h2A: raw_c = "v";  8'h1D: raw_c = "w";  8'h22: raw_c = "x";
      8'h35: raw_c = "y";  8'h1A: raw_c = "z";
      8'h45: raw_c = "0";  8'h16: raw_c = "1";  8'h1E: raw_c = "2";  8'h26: raw_c = "3";
      8'h25: raw_c = "4";  8'h2E: raw_c = "5";  8'h36: raw_c = "6";  8'h3D: raw_c = "7";
      8'h3E: raw_c = "8";  8'h46: raw_c = "9";
      8'h29: raw_c = 8'h20;
      8'h5A: raw_c = 8'h0D;
      8'h66: raw_c = 8'h08;
      default: raw_c = 8'h00;
    endcase
    is_letter_c = (raw_c >= "a") && (raw_c <= "z");
    if (cur_ext_c || cur_brk_c) begin
      ascii_c = 8'h00;
    end else if (is_letter_c && upper_c) begin
      ascii_c = raw_c - 8'h20;
    end else begin
      ascii_c = raw_c;
    end
    ev_c = '{code: scan_code, ext: cur_ext_c, brk: cur_brk_c, rep: rep_c, ascii: ascii_c};
  end

  // FIFO push/pop arbitration; a full FIFO still accepts a push if it pops the same cycle
  always_comb begin
    pop_c     = valid_q && ev_ready;
    full_c    = (level_q == LW'(DEPTH));
    push_ok_c = emit_c && (!full_c || pop_c);
    drop_c    = emit_c && full_c && !pop_c;
    level_d   = level_q + LW'(push_ok_c) - LW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      shl_q    <= 1'b0;
      shr_q    <= 1'b0;
      caps_q   <= 1'b0;
      ovf_q    <= 1'b0;
      press_q  <= 8'h00;
      last_q   <= 9'h000;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (scan_valid) begin
        case (state_q)
          IDLE:    state_q <= is_e0_c ? EXT : (is_f0_c ? BRK : IDLE);
          EXT:     state_q <= is_f0_c ? EXTBRK : (is_e0_c ? EXT : IDLE);
          BRK:     state_q <= is_f0_c ? BRK : (is_e0_c ? EXTBRK : IDLE);
          EXTBRK:  state_q <= (is_e0_c || is_f0_c) ? EXTBRK : IDLE;
          default: state_q <= IDLE;
        endcase
      end

      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= ev_c;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      valid_q <= (level_d != '0);
      if (drop_c) ovf_q <= 1'b1;

      // Key state tracks every decoded event, including dropped ones
      if (emit_c) begin
        if (!cur_brk_c) begin
          if (!rep_c) begin
            press_q <= press_q + 8'd1;
            last_q  <= key_c;
            if (!cur_ext_c && scan_code == 8'h58) caps_q <= ~caps_q;
          end
          if (!cur_ext_c && scan_code == 8'h12) shl_q <= 1'b1;
          if (!cur_ext_c && scan_code == 8'h59) shr_q <= 1'b1;
        end else begin
          if (key_c == last_q) last_q <= 9'h000;
          if (!cur_ext_c && scan_code == 8'h12) shl_q <= 1'b0;
          if (!cur_ext_c && scan_code == 8'h59) shr_q <= 1'b0;
        end
      end
    end
  end

  assign ev_valid    = valid_q;
  assign ev_code     = mem_q[rd_ptr_q].code;
  assign ev_ext      = mem_q[rd_ptr_q].ext;
  assign ev_break    = mem_q[rd_ptr_q].brk;
  assign ev_repeat   = mem_q[rd_ptr_q].rep;
  assign ev_ascii    = mem_q[rd_ptr_q].ascii;
  assign shift       = shl_q | shr_q;
  assign caps        = caps_q;
  assign press_count = press_q;
  assign fifo_level  = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a behavioural key model predicts events and
// key state; a monitor compares each popped event and the status outputs every cycle.
module tb_ps2_key_decoder;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          reset, scan_valid, ev_ready;
  logic [7:0]    scan_code;
  logic          ev_valid, ev_ext, ev_break, ev_repeat, shift, caps, overflow;
  logic [7:0]    ev_code, ev_ascii, press_count;
  logic [AW:0]   fifo_level;

  ps2_key_decoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_repeat(ev_repeat), .ev_ascii(ev_ascii), .shift(shift),
    .caps(caps), .press_count(press_count), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   chk_en   = 0;

  // Model of the key state after each clock edge
  bit        m_ext, m_brk, m_shl, m_shr, m_caps, m_ovf;
  bit [8:0]  m_last;
  bit [7:0]  m_press;
  int        m_level;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h1A, 8'h45, 8'h16, 8'h12, 8'h59, 8'h58,
                            8'h29, 8'h5A, 8'h66, 8'h75, 8'h6B, 8'h21, 8'hE0, 8'hF0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input bit ext, input bit brk,
                                          input bit up);
    if (ext || brk) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  // Reference model: updates on each active edge from the inputs driven before it
  always @(posedge clk) begin : model
    bit  pop, push;
    ev_t e;
    if (reset) begin
      m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0;
      m_last = '0; m_press = '0; m_level = 0;
      exp_q.delete();
    end else begin
      pop  = (m_level > 0) && ev_ready;
      push = 0;
      e    = '0;
      if (scan_valid) begin
        if (scan_code == 8'hE0) m_ext = 1;
        else if (scan_code == 8'hF0) m_brk = 1;
        else begin
          e.code  = scan_code;
          e.ext   = m_ext;
          e.brk   = m_brk;
          e.rep   = !m_brk && ({m_ext, scan_code} == m_last);
          e.ascii = ascii_of(scan_code, m_ext, m_brk, (m_shl | m_shr) ^ m_caps);
          push    = 1;
          if (!e.brk) begin
            if (!e.rep) begin
              m_press++;
              m_last = {e.ext, e.code};
              if (!e.ext && e.code == 8'h58) m_caps = !m_caps;
            end
            if (!e.ext && e.code == 8'h12) m_shl = 1;
            if (!e.ext && e.code == 8'h59) m_shr = 1;
          end else begin
            if ({e.ext, e.code} == m_last) m_last = '0;
            if (!e.ext && e.code == 8'h12) m_shl = 0;
            if (!e.ext && e.code == 8'h59) m_shr = 0;
          end
          m_ext = 0;
          m_brk = 0;
        end
      end
      if (push) begin
        if (m_level < int'(DEPTH) || pop) begin
          exp_q.push_back(e);
          m_level++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_level--;
    end
  end

  // Monitor: compares on the inactive edge, pops the scoreboard on each handshake
  always @(negedge clk) begin : monitor
    ev_t e;
    if (chk_en && !reset) begin
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got code %0h with no event expected", ev_code);
        end else begin
          e = exp_q.pop_front();
          check("event", 32'({ev_code, ev_ext, ev_break, ev_repeat, ev_ascii}), 32'(e));
        end
      end
      check("ev_valid", 32'(ev_valid), 32'(m_level > 0));
      check("fifo_level", 32'(fifo_level), 32'(m_level));
      check("shift", 32'(shift), 32'(m_shl | m_shr));
      check("caps", 32'(caps), 32'(m_caps));
      check("press_count", 32'(press_count), 32'(m_press));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Inputs change 1 time unit after the active edge
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    int thresh;
    int guard;
    reset = 1'b1; scan_valid = 1'b0; ev_ready = 1'b0; scan_code = 8'h00;
    @(posedge clk); #1;
    idle(1);
    reset  = 1'b0;
    chk_en = 1;
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_payload", 32'({ev_code, ev_ext, ev_break, ev_repeat, ev_ascii}), 0);

    // Plain make, then its break
    send(8'h1C);
    check("t1_valid", 32'(ev_valid), 1);
    check("t1_ascii", 32'(ev_ascii), 32'h61);
    check("t1_press", 32'(press_count), 1);
    ev_ready = 1'b1;
    send(8'hF0); send(8'h1C);
    idle(3);

    // Shift and caps interaction
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    check("t2_shift_off", 32'(shift), 0);
    send(8'h58);
    check("t2_caps", 32'(caps), 1);
    send(8'h1C);
    idle(3);

    // Extended make and break
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    idle(3);

    // Typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'h58); send(8'h58);
    check("t4_caps", 32'(caps), 0);
    send(8'hF0); send(8'h58);
    idle(4);

    // Overflow: nine distinct makes into a stalled FIFO
    ev_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    send(8'h35); send(8'h3C); send(8'h43); send(8'h44);
    check("t5_level", 32'(fifo_level), DEPTH);
    check("t5_overflow", 32'(overflow), 1);
    ev_ready = 1'b1;
    idle(12);

    // Reset discards a pending prefix
    send(8'hE0);
    pulse_reset();
    check("t6_press", 32'(press_count), 0);
    check("t6_level", 32'(fifo_level), 0);
    check("t6_overflow", 32'(overflow), 0);
    send(8'h1C);
    check("t6_ext", 32'(ev_ext), 0);
    idle(3);

    // Randomized traffic with alternating backpressure phases
    for (int i = 0; i < 1500; i++) begin
      thresh   = ((i / 300) % 2 == 1) ? 2 : 8;
      ev_ready = ($urandom_range(0, 9) < thresh);
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        r = $urandom_range(0, 19);
        if (r < 16) send(pool[r]);
        else send(8'($urandom_range(0, 255)));
      end
    end

    // Drain with a bounded wait
    ev_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      idle(1);
      guard++;
    end
    idle(2);
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
